phase_sequencer: RTL

- Multi-cycle instruction sequencer for the 8-bit accumulator CPU.
- Steps an 8-phase fetch/execute cycle and drives the datapath strobes for the program counter, instruction register, accumulator, address mux and memory, from the current opcode and the ALU zero flag.
- Adds a memory-ready handshake with a timeout, and a halt/resume mechanism.
- Sits between the instruction register and the datapath; replaces single-cycle opcode decoding for the control strobes.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/phase_sequencer_if.sv | 33 +++
 rtl/phase_sequencer_wait_timer.sv | 38 +++
 rtl/phase_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode encodings,
// sequencer phase encodings and the ALU-opcode classifier.
package cpu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] HLT = 3'd0;
  localparam logic [OP_W-1:0] SKZ = 3'd1;
  localparam logic [OP_W-1:0] ADD = 3'd2;
  localparam logic [OP_W-1:0] AND = 3'd3;
  localparam logic [OP_W-1:0] XOR = 3'd4;
  localparam logic [OP_W-1:0] LDA = 3'd5;
  localparam logic [OP_W-1:0] STO = 3'd6;
  localparam logic [OP_W-1:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read a memory operand and write the accumulator
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control-side bundle between the sequencer and the rest of the CPU:
// opcode/status/handshake inputs plus the datapath strobes it drives.
interface phase_sequencer_if;
  import cpu_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;
  logic            resume;

  logic            sel;
  logic            rd;
  logic            wr;
  logic            ld_ir;
  logic            inc_pc;
  logic            ld_pc;
  logic            ld_ac;
  logic            data_e;
  logic            halt;
  logic [2:0]      phase;
  logic            mem_err;

  modport master (
    output opcode, zero, mem_ready, resume,
    input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase, mem_err
  );

  modport slave (
    input  opcode, zero, mem_ready, resume,
    output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase, mem_err
  );

endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// Consecutive wait-state counter; expired flags that TIMEOUT held cycles
// have already elapsed, and the count saturates there.
module wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Eight-phase fetch/execute sequencer: decodes datapath strobes from phase,
// opcode and zero, with memory wait states, timeout fault and HLT/resume.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  phase_sequencer_if.slave  bus
);

  phase_e phase_q;
  phase_e phase_d;
  logic   mem_err_q;
  logic   mem_err_d;

  logic   alu_op;
  logic   wait_phase;
  logic   hlt_stop;
  logic   tmr_clr;
  logic   tmr_en;
  logic   expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  assign alu_op     = is_aluop(bus.opcode);
  assign wait_phase = (phase_q == INST_FETCH) || ((phase_q == OP_FETCH) && alu_op);
  assign hlt_stop   = (phase_q == OP_ADDR) && (bus.opcode == HLT);

  always_comb begin
    phase_d    = phase_q;
    mem_err_d  = mem_err_q;
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;

    // A latched fault freezes the sequencer with every strobe quiet
    if (mem_err_q) begin
      bus.halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          bus.sel = 1'b1;
        end
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          if (bus.opcode == HLT) begin
            bus.halt   = !bus.resume;
            bus.inc_pc = bus.resume;
          end else begin
            bus.inc_pc = 1'b1;
          end
        end
        OP_FETCH: begin
          bus.rd = alu_op;
        end
        ALU_OP: begin
          bus.rd     = alu_op;
          bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
          bus.ld_pc  = (bus.opcode == JMP);
          bus.data_e = (bus.opcode == STO);
        end
        STORE: begin
          bus.rd     = alu_op;
          bus.ld_ac  = alu_op;
          bus.ld_pc  = (bus.opcode == JMP);
          bus.wr     = (bus.opcode == STO);
          bus.data_e = (bus.opcode == STO);
        end
        default: ;
      endcase

      // mem_ready on the expiry cycle still advances, so no fault is raised
      if (wait_phase && !bus.mem_ready) begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        if (expired) begin
          mem_err_d = 1'b1;
        end
      end else if (!(hlt_stop && !bus.resume)) begin
        phase_d = phase_e'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= INST_ADDR;
      mem_err_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.phase   = phase_q;
  assign bus.mem_err = mem_err_q;

endmodule
